mbf_mac_sched: RTL and testbench

- Area-reduced replacement for the dual parallel FIR banks in the multi-bank filter top.
- One shared 8x20-bit multiply-accumulate unit, time-multiplexed between the low-pass bank (y) and the high-pass bank (z).
- A FSM sequences 16 MAC cycles per bank for each accepted sample.
- Sits between the sample source (ROM reader, valid/data) and the y/z output ports; back-pressures the source through in_ready.

---
 rtl/mbf_pkg.sv | 40 ++++
 rtl/mbf_mac.sv | 22 ++
 rtl/mbf_mac_sched.sv | 117 +++++++++++
 tb/tb_mbf_mac_sched.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mbf_pkg.sv
// rtl/mbf_pkg.sv - shared constants, coefficients and helpers for the time-multiplexed FIR MAC
package mbf_pkg;

    localparam int DATA_W  = 8;
    localparam int ACC_W   = 20;
    localparam int TAPS    = 16;
    localparam int IDX_W   = 4;
    localparam int RND_MSB = 16;

    typedef enum logic [1:0] {
        IDLE,
        MAC_L,
        MAC_H
    } state_t;

    localparam logic signed [ACC_W-1:0] LOW_COEFF [0:TAPS-1] = '{
        -20'sd1,   -20'sd2,   20'sd4,    20'sd12,
        -20'sd24,  -20'sd40,  20'sd80,   20'sd256,
        20'sd256,  20'sd80,   -20'sd40,  -20'sd24,
        20'sd12,   20'sd4,    -20'sd2,   -20'sd1
    };

    // High-pass bank is the low-pass set with every odd tap negated.
    function automatic logic signed [ACC_W-1:0] tap_coeff(
        input logic             high,
        input logic [IDX_W-1:0] idx
    );
        logic signed [ACC_W-1:0] c;
        c = LOW_COEFF[idx];
        if (high && idx[0]) begin
            c = -c;
        end
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] round_out(input logic [RND_MSB:0] a);
        return a[RND_MSB:RND_MSB-DATA_W+1] + {{(DATA_W-1){1'b0}}, a[RND_MSB-DATA_W]};
    endfunction

endpackage

// File: rtl/mbf_mac.sv
// rtl/mbf_mac.sv - combinational coefficient select, multiply and accumulate step
module mbf_mac
    import mbf_pkg::*;
(
    input  logic                    bank,
    input  logic [IDX_W-1:0]        idx,
    input  logic signed [ACC_W-1:0] sample,
    input  logic [ACC_W-1:0]        acc,
    output logic [ACC_W-1:0]        acc_next
);

    logic signed [ACC_W-1:0] coeff;
    logic signed [ACC_W-1:0] product;

    // Product keeps only ACC_W bits, so the accumulator wraps modulo 2^ACC_W.
    always_comb begin
        coeff    = tap_coeff(bank, idx);
        product  = coeff * sample;
        acc_next = acc + product;
    end

endmodule

// File: rtl/mbf_mac_sched.sv
// rtl/mbf_mac_sched.sv - low/high-pass FIR pair sharing one MAC, 16 cycles per bank per sample
module mbf_mac_sched
    import mbf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              clr,
    output logic [DATA_W-1:0] y,
    output logic              y_valid,
    output logic [DATA_W-1:0] z,
    output logic              z_valid,
    output logic              busy
);

    state_t                  state;
    state_t                  state_next;
    logic signed [ACC_W-1:0] hist [0:TAPS-1];
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        acc_next;
    logic [IDX_W-1:0]        idx;
    logic                    accept;
    logic                    last_tap;

    assign in_ready = (state == IDLE);
    assign busy     = !in_ready;
    assign accept   = in_valid && in_ready;
    assign last_tap = (idx == IDX_W'(TAPS - 1));

    mbf_mac u_mac (
        .bank     (state == MAC_H),
        .idx      (idx),
        .sample   (hist[idx]),
        .acc      (acc),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)   state_next = MAC_L;
            MAC_L:   if (last_tap) state_next = MAC_H;
            MAC_H:   if (last_tap) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) begin
                hist[k] <= '0;
            end
            acc     <= '0;
            idx     <= '0;
            y       <= '0;
            z       <= '0;
            y_valid <= 1'b0;
            z_valid <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            z_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int k = TAPS - 1; k > 0; k--) begin
                            hist[k] <= hist[k-1];
                        end
                        hist[0] <= {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
                        acc     <= '0;
                        idx     <= '0;
                    end else if (clr) begin
                        for (int k = 0; k < TAPS; k++) begin
                            hist[k] <= '0;
                        end
                    end
                end
                MAC_L: begin
                    if (last_tap) begin
                        y       <= round_out(acc_next[RND_MSB:0]);
                        y_valid <= 1'b1;
                        acc     <= '0;
                        idx     <= '0;
                    end else begin
                        acc <= acc_next;
                        idx <= idx + 1'b1;
                    end
                end
                MAC_H: begin
                    if (last_tap) begin
                        z       <= round_out(acc_next[RND_MSB:0]);
                        z_valid <= 1'b1;
                        acc     <= '0;
                        idx     <= '0;
                    end else begin
                        acc <= acc_next;
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    acc <= '0;
                    idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mbf_mac_sched.sv
// tb/tb_mbf_mac_sched.sv - directed self-checking bench for mbf_mac_sched
module tb_mbf_mac_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       clr = 1'b0;
    logic       in_ready;
    logic [7:0] y;
    logic       y_valid;
    logic [7:0] z;
    logic       z_valid;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int overlap = 0;

    mbf_mac_sched dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .clr      (clr),
        .y        (y),
        .y_valid  (y_valid),
        .z        (z),
        .z_valid  (z_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (y_valid && z_valid) overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_sample(input logic [7:0] d, input bit clr_mid,
                              output logic [7:0] yo, output logic [7:0] zo,
                              output int yl, output int zl, output int ypc);
        int n;
        n   = 0;
        yl  = -1;
        zl  = -1;
        ypc = 0;
        yo  = 8'hxx;
        zo  = 8'hxx;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 40 && zl < 0; k++) begin
            clr = clr_mid && (k < 10);
            @(posedge clk); #1;
            if (y_valid) begin ypc++; yl = k; yo = y; end
            if (z_valid) begin zl = k; zo = z; end
        end
        clr = 1'b0;
    endtask

    task automatic run_impulse(input bit clr_mid, output logic [7:0] yo, output logic [7:0] zo,
                               output int yl, output int zl, output int ypc);
        logic [7:0] ty, tz;
        int a, b, c;
        run_sample(8'd8, clr_mid, ty, tz, yl, zl, ypc);
        for (int i = 0; i < 7; i++) run_sample(8'd0, 1'b0, ty, tz, a, b, c);
        yo = ty;
        zo = tz;
    endtask

    logic [7:0] ry, rz;
    int yl, zl, ypc;
    int rdy_cnt, vcnt, busy_cnt;
    int nacc, last_acc, bad_gap, lowrun, bad_low;
    bit rdy;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        rdy_cnt = 0; vcnt = 0; busy_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            rdy_cnt  += int'(in_ready);
            busy_cnt += int'(busy);
            vcnt     += int'(y_valid) + int'(z_valid);
        end
        chk("idle_y", {24'd0, y}, 32'h00);
        chk("idle_z", {24'd0, z}, 32'h00);
        chk("idle_ready_cycles", rdy_cnt, 50);
        chk("idle_busy_cycles", busy_cnt, 0);
        chk("idle_valid_pulses", vcnt, 0);

        run_impulse(1'b0, ry, rz, yl, zl, ypc);
        chk("impulse_y", {24'd0, ry}, 32'h04);
        chk("impulse_z", {24'd0, rz}, 32'hFC);
        chk("y_valid_latency", yl, 16);
        chk("z_valid_latency", zl, 32);
        chk("y_valid_pulses", ypc, 1);

        for (int i = 0; i < 16; i++) run_sample(8'd1, 1'b0, ry, rz, yl, zl, ypc);
        chk("const1_y", {24'd0, ry}, 32'h01);
        chk("const1_z", {24'd0, rz}, 32'h00);
        for (int i = 0; i < 16; i++) run_sample(8'd100, 1'b0, ry, rz, yl, zl, ypc);
        chk("const100_y", {24'd0, ry}, 32'h6F);
        chk("const100_z", {24'd0, rz}, 32'h00);

        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'd10;
        nacc = 0; last_acc = 0; bad_gap = 0; lowrun = 0; bad_low = 0;
        for (int c = 0; c < 8 * 33 + 10 && nacc < 8; c++) begin
            @(negedge clk);
            rdy = in_ready;
            if (!rdy) lowrun++;
            @(posedge clk); #1;
            if (rdy) begin
                if (nacc > 0 && (c - last_acc) != 33) bad_gap++;
                if (nacc > 0 && lowrun != 32) bad_low++;
                lowrun   = 0;
                last_acc = c;
                nacc++;
                in_data  = in_data + 8'd10;
                if (nacc == 8) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        repeat (34) @(posedge clk);
        #1;
        chk("stream_accepts", nacc, 8);
        chk("stream_bad_gaps", bad_gap, 0);
        chk("stream_bad_ready_low", bad_low, 0);
        chk("stream_y", {24'd0, y}, 32'h05);
        chk("stream_z", {24'd0, z}, 32'hFE);

        in_valid = 1'b1;
        in_data  = 8'd50;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("reset_y", {24'd0, y}, 32'h00);
        chk("reset_z", {24'd0, z}, 32'h00);
        chk("reset_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            vcnt += int'(y_valid) + int'(z_valid);
        end
        chk("reset_no_pulse", vcnt, 0);
        run_impulse(1'b0, ry, rz, yl, zl, ypc);
        chk("post_reset_y", {24'd0, ry}, 32'h04);
        chk("post_reset_z", {24'd0, rz}, 32'hFC);

        for (int i = 0; i < 16; i++) run_sample(8'd100, 1'b0, ry, rz, yl, zl, ypc);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        run_impulse(1'b0, ry, rz, yl, zl, ypc);
        chk("clr_idle_y", {24'd0, ry}, 32'h04);
        chk("clr_idle_z", {24'd0, rz}, 32'hFC);

        run_impulse(1'b1, ry, rz, yl, zl, ypc);
        chk("clr_busy_y", {24'd0, ry}, 32'h04);
        chk("clr_busy_z", {24'd0, rz}, 32'hFC);

        chk("valid_overlap", overlap, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
